// File: rtl/i2c_rx_deserializer.sv
// ----------------------------------------------------------------------------
// i2c_rx_deserializer
//  I2C slave receive front end. Synchronises the raw SDA/SCL pad lines,
//  detects START / repeated START / STOP, matches the 7-bit device address
//  {DEV_ID, i2c_addr_bits}, shifts in ADDR_BYTES big-endian register-address
//  bytes followed by any number of write-data bytes, and requests ACK slots
//  from the serializer. Read transfers are tracked but not captured.
//
//  Optional feature: define I2C_RX_AUTOINC_EN to post-increment i2c_addr
//  after every write-data byte and after every read byte's ACK/NACK slot.
//
// Ports
//  Clock          system clock, rising edge
//  Reset          asynchronous active-low reset
//  i2c_sda_raw    unsynchronised SDA from pad
//  i2c_scl_raw    unsynchronised SCL from pad
//  i2c_addr_bits  device-address strap pins
//  i2c_RW         R/W bit of the last matched device byte (1 = read)
//  i2c_addr       current register address
//  addr_xfc       1-cycle pulse, final address byte acknowledged
//  i2c_ack        ask serializer to hold SDA low during the ACK slot
//  data_xfc       1-cycle pulse, write-data byte valid on serial_data
//  serial_data    last received write-data byte
//  stop_out       1 = bus idle (STOP seen or reset)
//  busy           1 = transfer in progress after START
// ----------------------------------------------------------------------------
module i2c_rx_deserializer #(
    parameter int                  SYNC_STAGES = 3,
    parameter int                  PIN_BITS    = 3,
    parameter logic [6-PIN_BITS:0] DEV_ID      = 4'b1010,
    parameter int                  ADDR_BYTES  = 2,
    parameter int                  ADDR_W      = 11
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                i2c_sda_raw,
    input  logic                i2c_scl_raw,
    input  logic [PIN_BITS-1:0] i2c_addr_bits,
    output logic                i2c_RW,
    output logic [ADDR_W-1:0]   i2c_addr,
    output logic                addr_xfc,
    output logic                i2c_ack,
    output logic                data_xfc,
    output logic [7:0]          serial_data,
    output logic                stop_out,
    output logic                busy
);

    localparam int ACC_W = 8 * ADDR_BYTES;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_DEV      = 4'd1,
        ST_DEV_ACK  = 4'd2,
        ST_ADDR     = 4'd3,
        ST_ADDR_ACK = 4'd4,
        ST_DATA     = 4'd5,
        ST_DATA_ACK = 4'd6,
        ST_READ     = 4'd7,
        ST_READ_ACK = 4'd8
    } state_t;

    // Synchroniser chains and previous synced values for edge detection
    logic [SYNC_STAGES-1:0] scl_sync_r;
    logic [SYNC_STAGES-1:0] sda_sync_r;
    logic                   scl_d_r;
    logic                   sda_d_r;

    logic scl_s, sda_s;
    logic scl_rise_s, scl_fall_s, sda_rise_s, sda_fall_s;
    logic start_s, stop_s;

    // Registered state and its next-state values
    state_t            state_r,  state_n;
    logic [2:0]        bit_cnt_r, bit_cnt_n;
    logic              full_r,   full_n;     // 8 bits shifted, waiting for SCL fall
    logic [7:0]        shift_r,  shift_n;
    logic [1:0]        abyte_r,  abyte_n;    // index of address byte in progress
    logic [ACC_W-1:0]  acc_r,    acc_n;      // address bytes concatenated MSB first
    logic              rw_r,     rw_n;
    logic [ADDR_W-1:0] addr_r,   addr_n;
    logic              ack_r,    ack_n;
    logic [7:0]        data_r,   data_n;
    logic              axfc_r,   axfc_n;
    logic              dxfc_r,   dxfc_n;
    logic              stop_r,   stop_n;
    logic              busy_r,   busy_n;

    // Device address match against strap-extended DEV_ID
    function automatic logic dev_match(input logic [7:0] dev_byte,
                                       input logic [PIN_BITS-1:0] pins);
        return (dev_byte[7:1] == {DEV_ID, pins});
    endfunction

    // Raw pad lines into multi-flop synchronisers; idle bus level is high
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            scl_sync_r <= {SYNC_STAGES{1'b1}};
            sda_sync_r <= {SYNC_STAGES{1'b1}};
            scl_d_r    <= 1'b1;
            sda_d_r    <= 1'b1;
        end else begin
            scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], i2c_scl_raw};
            sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], i2c_sda_raw};
            scl_d_r    <= scl_sync_r[SYNC_STAGES-1];
            sda_d_r    <= sda_sync_r[SYNC_STAGES-1];
        end
    end

    assign scl_s      = scl_sync_r[SYNC_STAGES-1];
    assign sda_s      = sda_sync_r[SYNC_STAGES-1];
    assign scl_rise_s =  scl_s & ~scl_d_r;
    assign scl_fall_s = ~scl_s &  scl_d_r;
    assign sda_rise_s =  sda_s & ~sda_d_r;
    assign sda_fall_s = ~sda_s &  sda_d_r;
    assign start_s    = sda_fall_s & scl_s;
    assign stop_s     = sda_rise_s & scl_s;

    // Next-state and output logic; bus conditions take priority over bit events
    always_comb begin
        state_n   = state_r;
        bit_cnt_n = bit_cnt_r;
        full_n    = full_r;
        shift_n   = shift_r;
        abyte_n   = abyte_r;
        acc_n     = acc_r;
        rw_n      = rw_r;
        addr_n    = addr_r;
        ack_n     = ack_r;
        data_n    = data_r;
        axfc_n    = 1'b0;
        dxfc_n    = 1'b0;
        stop_n    = stop_r;
        busy_n    = busy_r;

`ifdef I2C_RX_AUTOINC_EN
        // Post-increment the cycle after a data byte was delivered
        if (dxfc_r) begin
            addr_n = addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        end else begin
            addr_n = addr_r;
        end
`endif

        if (stop_s) begin
            state_n   = ST_IDLE;
            bit_cnt_n = 3'd0;
            full_n    = 1'b0;
            ack_n     = 1'b0;
            stop_n    = 1'b1;
            busy_n    = 1'b0;
        end else if (start_s) begin
            state_n   = ST_DEV;
            bit_cnt_n = 3'd0;
            full_n    = 1'b0;
            ack_n     = 1'b0;
            stop_n    = 1'b0;
            busy_n    = 1'b1;
        end else begin
            // Shift one bit per SCL rise in the byte-receiving states
            if (scl_rise_s && (state_r inside {ST_DEV, ST_ADDR, ST_DATA, ST_READ})) begin
                shift_n = {shift_r[6:0], sda_s};
                if (bit_cnt_r == 3'd7) begin
                    bit_cnt_n = 3'd0;
                    full_n    = 1'b1;
                end else begin
                    bit_cnt_n = bit_cnt_r + 3'd1;
                end
            end else begin
                shift_n = shift_r;
            end

            case (state_r)
                ST_IDLE: begin
                    state_n = ST_IDLE;
                end
                ST_DEV: begin
                    if (scl_fall_s && full_r) begin
                        full_n = 1'b0;
                        if (dev_match(shift_r, i2c_addr_bits)) begin
                            ack_n   = 1'b1;
                            rw_n    = shift_r[0];
                            state_n = ST_DEV_ACK;
                        end else begin
                            busy_n  = 1'b0;
                            state_n = ST_IDLE;
                        end
                    end else begin
                        state_n = ST_DEV;
                    end
                end
                ST_DEV_ACK: begin
                    if (scl_fall_s) begin
                        ack_n   = 1'b0;
                        abyte_n = 2'd0;
                        acc_n   = {ACC_W{1'b0}};
                        state_n = rw_r ? ST_READ : ST_ADDR;
                    end else begin
                        state_n = ST_DEV_ACK;
                    end
                end
                ST_ADDR: begin
                    if (scl_fall_s && full_r) begin
                        full_n  = 1'b0;
                        acc_n   = (acc_r << 8) | ACC_W'(shift_r);
                        ack_n   = 1'b1;
                        state_n = ST_ADDR_ACK;
                    end else begin
                        state_n = ST_ADDR;
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall_s) begin
                        ack_n = 1'b0;
                        if (abyte_r == 2'(ADDR_BYTES - 1)) begin
                            addr_n  = acc_r[ADDR_W-1:0];
                            axfc_n  = 1'b1;
                            state_n = ST_DATA;
                        end else begin
                            abyte_n = abyte_r + 2'd1;
                            state_n = ST_ADDR;
                        end
                    end else begin
                        state_n = ST_ADDR_ACK;
                    end
                end
                ST_DATA: begin
                    if (scl_fall_s && full_r) begin
                        full_n  = 1'b0;
                        data_n  = shift_r;
                        dxfc_n  = 1'b1;
                        ack_n   = 1'b1;
                        state_n = ST_DATA_ACK;
                    end else begin
                        state_n = ST_DATA;
                    end
                end
                ST_DATA_ACK: begin
                    if (scl_fall_s) begin
                        ack_n   = 1'b0;
                        state_n = ST_DATA;
                    end else begin
                        state_n = ST_DATA_ACK;
                    end
                end
                ST_READ: begin
                    // Bits are counted only to locate the master's ACK/NACK slot
                    if (scl_fall_s && full_r) begin
                        full_n  = 1'b0;
                        state_n = ST_READ_ACK;
                    end else begin
                        state_n = ST_READ;
                    end
                end
                ST_READ_ACK: begin
                    if (scl_fall_s) begin
                        state_n = ST_READ;
`ifdef I2C_RX_AUTOINC_EN
                        addr_n  = addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
`endif
                    end else begin
                        state_n = ST_READ_ACK;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 3'd0;
            full_r    <= 1'b0;
            shift_r   <= 8'd0;
            abyte_r   <= 2'd0;
            acc_r     <= {ACC_W{1'b0}};
            rw_r      <= 1'b0;
            addr_r    <= {ADDR_W{1'b0}};
            ack_r     <= 1'b0;
            data_r    <= 8'd0;
            axfc_r    <= 1'b0;
            dxfc_r    <= 1'b0;
            stop_r    <= 1'b1;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_n;
            bit_cnt_r <= bit_cnt_n;
            full_r    <= full_n;
            shift_r   <= shift_n;
            abyte_r   <= abyte_n;
            acc_r     <= acc_n;
            rw_r      <= rw_n;
            addr_r    <= addr_n;
            ack_r     <= ack_n;
            data_r    <= data_n;
            axfc_r    <= axfc_n;
            dxfc_r    <= dxfc_n;
            stop_r    <= stop_n;
            busy_r    <= busy_n;
        end
    end

    assign i2c_RW      = rw_r;
    assign i2c_addr    = addr_r;
    assign addr_xfc    = axfc_r;
    assign i2c_ack     = ack_r;
    assign data_xfc    = dxfc_r;
    assign serial_data = data_r;
    assign stop_out    = stop_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_i2c_rx_deserializer.sv
// ----------------------------------------------------------------------------
// tb_i2c_rx_deserializer
//  Directed bench: drives I2C master waveforms on the raw pad inputs and
//  checks ACK slots, transfer pulses, captured data/address and bus flags
//  against hand-computed values.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2c_rx_deserializer;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        sda   = 1'b1;
    logic        scl   = 1'b1;
    logic [2:0]  strap = 3'b101;

    logic        i2c_RW;
    logic [10:0] i2c_addr;
    logic        addr_xfc;
    logic        i2c_ack;
    logic        data_xfc;
    logic [7:0]  serial_data;
    logic        stop_out;
    logic        busy;

    i2c_rx_deserializer dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .i2c_sda_raw   (sda),
        .i2c_scl_raw   (scl),
        .i2c_addr_bits (strap),
        .i2c_RW        (i2c_RW),
        .i2c_addr      (i2c_addr),
        .addr_xfc      (addr_xfc),
        .i2c_ack       (i2c_ack),
        .data_xfc      (data_xfc),
        .serial_data   (serial_data),
        .stop_out      (stop_out),
        .busy          (busy)
    );

    always #5 Clock = ~Clock;

    int n_cmp  = 0;
    int n_fail = 0;

    // Pulse monitor: counts every cycle a pulse is high, captures values
    int          axfc_cnt = 0;
    int          dxfc_cnt = 0;
    logic [10:0] axfc_addr = 11'd0;
    logic [7:0]  dq[$];
    logic [10:0] daq[$];

    always @(negedge Clock) begin
        if (addr_xfc) begin
            axfc_cnt  <= axfc_cnt + 1;
            axfc_addr <= i2c_addr;
        end
        if (data_xfc) begin
            dxfc_cnt <= dxfc_cnt + 1;
            dq.push_back(serial_data);
            daq.push_back(i2c_addr);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One quarter bit period, inputs change 2 ns after a clock edge
    task automatic wq();
        repeat (10) @(posedge Clock);
        #2;
    endtask

    task automatic start_c();
        sda = 1'b1; wq();
        scl = 1'b1; wq();
        sda = 1'b0; wq();
        scl = 1'b0; wq();
    endtask

    task automatic stop_c();
        sda = 1'b0; wq();
        scl = 1'b1; wq();
        sda = 1'b1; wq();
    endtask

    task automatic send_bit(input logic b);
        sda = b;    wq();
        scl = 1'b1; wq(); wq();
        scl = 1'b0; wq();
    endtask

    // Eight bits MSB first then a released-SDA ACK clock; ack = i2c_ack mid-slot
    task automatic send_byte(input logic [7:0] b, output int ack);
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i]);
        end
        sda = 1'b1; wq();
        scl = 1'b1; wq();
        ack = (i2c_ack === 1'b1) ? 1 : 0;
        wq();
        scl = 1'b0; wq();
    endtask

    int a, acks, a0, d0;
    logic [10:0] exp_a1, exp_a2, exp_fin;

    initial begin
        // Reset state
        repeat (5) @(posedge Clock);
        #2;
        check("rst_stop_out", 32'(stop_out), 32'd1);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_ack",      32'(i2c_ack),  32'd0);
        check("rst_addr",     32'(i2c_addr), 32'd0);
        check("rst_sdata",    32'(serial_data), 32'd0);
        check("rst_rw",       32'(i2c_RW),   32'd0);
        Reset = 1'b1;
        wq(); wq();

        // Basic write: dev 0xAA, addr 0x05 0x3C, data 0x5A
        a0 = axfc_cnt; d0 = dxfc_cnt;
        start_c();
        send_byte(8'hAA, a); acks = a;
        send_byte(8'h05, a); acks += a;
        send_byte(8'h3C, a); acks += a;
        send_byte(8'h5A, a); acks += a;
        check("w1_busy_mid",  32'(busy),     32'd1);
        check("w1_stop_mid",  32'(stop_out), 32'd0);
        stop_c(); wq();
        check("w1_acks",      32'(acks),          32'd4);
        check("w1_axfc_cnt",  32'(axfc_cnt - a0), 32'd1);
        check("w1_axfc_addr", 32'(axfc_addr),     32'h53C);
        check("w1_dxfc_cnt",  32'(dxfc_cnt - d0), 32'd1);
        check("w1_sdata",     32'(dq[d0]),        32'h5A);
        check("w1_stop_out",  32'(stop_out),      32'd1);
        check("w1_busy",      32'(busy),          32'd0);
        check("w1_rw",        32'(i2c_RW),        32'd0);

        // Address mismatch: dev 0xA2 with strap 101, following bytes ignored
        a0 = axfc_cnt; d0 = dxfc_cnt;
        start_c();
        send_byte(8'hA2, a); acks = a;
        send_byte(8'h05, a); acks += a;
        send_byte(8'h3C, a); acks += a;
        send_byte(8'h77, a); acks += a;
        stop_c(); wq();
        check("mm_acks",      32'(acks),          32'd0);
        check("mm_axfc_cnt",  32'(axfc_cnt - a0), 32'd0);
        check("mm_dxfc_cnt",  32'(dxfc_cnt - d0), 32'd0);
        check("mm_addr",      32'(i2c_addr),      32'h53C);
        check("mm_sdata",     32'(serial_data),   32'h5A);

        // Burst write from 0x7FF
`ifdef I2C_RX_AUTOINC_EN
        exp_a1 = 11'h000; exp_a2 = 11'h001; exp_fin = 11'h002;
`else
        exp_a1 = 11'h7FF; exp_a2 = 11'h7FF; exp_fin = 11'h7FF;
`endif
        a0 = axfc_cnt; d0 = dxfc_cnt;
        start_c();
        send_byte(8'hAA, a); acks = a;
        send_byte(8'h07, a); acks += a;
        send_byte(8'hFF, a); acks += a;
        send_byte(8'h11, a); acks += a;
        send_byte(8'h22, a); acks += a;
        send_byte(8'h33, a); acks += a;
        stop_c(); wq();
        check("bw_acks",      32'(acks),          32'd6);
        check("bw_axfc_addr", 32'(axfc_addr),     32'h7FF);
        check("bw_dxfc_cnt",  32'(dxfc_cnt - d0), 32'd3);
        check("bw_d0",        32'(dq[d0]),        32'h11);
        check("bw_d1",        32'(dq[d0+1]),      32'h22);
        check("bw_d2",        32'(dq[d0+2]),      32'h33);
        check("bw_a0",        32'(daq[d0]),       32'h7FF);
        check("bw_a1",        32'(daq[d0+1]),     32'(exp_a1));
        check("bw_a2",        32'(daq[d0+2]),     32'(exp_a2));
        check("bw_final",     32'(i2c_addr),      32'(exp_fin));

        // Write address 0x0010 then repeated START into a read
        a0 = axfc_cnt; d0 = dxfc_cnt;
        start_c();
        send_byte(8'hAA, a);
        send_byte(8'h00, a);
        send_byte(8'h10, a);
        start_c();
        send_byte(8'hAB, a);
        check("rd_dev_ack",   32'(a),             32'd1);
        check("rd_rw",        32'(i2c_RW),        32'd1);
        check("rd_addr",      32'(i2c_addr),      32'h010);
        check("rd_busy",      32'(busy),          32'd1);
        check("rd_stop_out",  32'(stop_out),      32'd0);
        stop_c(); wq();
        check("rd_dxfc_cnt",  32'(dxfc_cnt - d0), 32'd0);
        check("rd_axfc_cnt",  32'(axfc_cnt - a0), 32'd1);
        check("rd_stop_end",  32'(stop_out),      32'd1);

        // STOP after 4 data bits: partial byte dropped
        d0 = dxfc_cnt;
        start_c();
        send_byte(8'hAA, a);
        send_byte(8'h01, a);
        send_byte(8'h23, a);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        check("ps_stop_pre",  32'(stop_out),      32'd0);
        stop_c(); wq();
        check("ps_dxfc_cnt",  32'(dxfc_cnt - d0), 32'd0);
        check("ps_sdata",     32'(serial_data),   32'h33);
        check("ps_stop_out",  32'(stop_out),      32'd1);
        check("ps_addr",      32'(i2c_addr),      32'h123);
        check("ps_ack",       32'(i2c_ack),       32'd0);

        // Reset in the middle of an address byte, then a clean write
        start_c();
        send_byte(8'hAA, a);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        Reset = 1'b0;
        #3;
        check("mr_stop_out",  32'(stop_out),    32'd1);
        check("mr_busy",      32'(busy),        32'd0);
        check("mr_addr",      32'(i2c_addr),    32'd0);
        check("mr_sdata",     32'(serial_data), 32'd0);
        check("mr_ack",       32'(i2c_ack),     32'd0);
        check("mr_rw",        32'(i2c_RW),      32'd0);
        sda = 1'b1; scl = 1'b1;
        wq(); wq();
        Reset = 1'b1;
        wq(); wq();
        a0 = axfc_cnt; d0 = dxfc_cnt;
        start_c();
        send_byte(8'hAA, a); acks = a;
        send_byte(8'h02, a); acks += a;
        send_byte(8'h34, a); acks += a;
        send_byte(8'hC3, a); acks += a;
        stop_c(); wq();
        check("mr_acks",      32'(acks),          32'd4);
        check("mr_axfc_addr", 32'(axfc_addr),     32'h234);
        check("mr_dxfc_cnt",  32'(dxfc_cnt - d0), 32'd1);
        check("mr_d0",        32'(dq[d0]),        32'hC3);
        check("mr_stop_end",  32'(stop_out),      32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
